// File: rtl/scroll_display_pkg.sv
// Shared seven-segment definitions for the scroll_display controller:
// segment bit order, blank pattern, and the hex glyph table with its decoder.
package scroll_display_pkg;

    // Cathode bit positions within the 7-bit segment bus {g,f,e,d,c,b,a}.
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    // All segments off (cathodes are active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low hex glyphs, entry 0 in the least significant slot.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg_scanner.sv
// Digit multiplexer: dwell counter, digit index, registered anode/cathode.
// Optional feature macro: SCROLL_GHOST_BLANK_EN inserts one blank cycle on
// every digit change so the previous digit cannot ghost onto the next one.
module seg_scanner
    import scroll_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    localparam int IW = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_i,
    output logic [IW-1:0]         idx_o,
    output logic [NUM_DIGITS-1:0] anode_o,
    output logic [6:0]            cathode_o
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]         CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT0   = NUM_DIGITS'(1);

    logic [CW-1:0]         scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            cathode_q, cathode_d;
    logic                  wrap_s;

    assign wrap_s    = (scan_cnt_q == CNT_LAST);
    assign idx_o     = idx_q;
    assign anode_o   = anode_q;
    assign cathode_o = cathode_q;

    // Advance the dwell counter and digit index; select the next anode/cathode pattern.
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        idx_d      = idx_q;
        anode_d    = ~(DIGIT0 << idx_q);
        cathode_d  = seg_i;
        if (wrap_s) begin
            scan_cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            scan_cnt_d = scan_cnt_q + CW'(1);
        end
`ifdef SCROLL_GHOST_BLANK_EN
        if (wrap_s) begin
            anode_d   = '1;
            cathode_d = SEG_OFF;
        end else begin
            anode_d   = ~(DIGIT0 << idx_q);
            cathode_d = seg_i;
        end
`endif
    end

    // Scan state and display pins; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            anode_q    <= '1;
            cathode_q  <= SEG_OFF;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            anode_q    <= anode_d;
            cathode_q  <= cathode_d;
        end
    end

endmodule

// File: rtl/scroll_display.sv
// Scrolling seven-segment controller: message buffer, scroll offset and
// step timer, window mux feeding the seg_scanner digit multiplexer.
// Optional feature macro: SCROLL_GHOST_BLANK_EN (handled in seg_scanner).
module scroll_display
    import scroll_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BUF_DIGITS = 16,
    parameter int SCAN_DIV   = 100000,
    parameter int STEP_W     = 27,
    localparam int AW = $clog2(BUF_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  run,
    input  logic                  dir,
    input  logic [STEP_W-1:0]     step_div,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            cathode,
    output logic                  step_pulse
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [AW-1:0] OFF_LAST = AW'(BUF_DIGITS - 1);
    localparam logic [AW:0]   BUF_LEN  = (AW + 1)'(BUF_DIGITS);

    logic [3:0]        msg_q [BUF_DIGITS];
    logic [3:0]        msg_d [BUF_DIGITS];
    logic [AW-1:0]     offset_q, offset_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              step_pulse_q, step_pulse_d;
    logic              step_s;
    logic              wr_ok_s;
    logic [IW-1:0]     scan_idx_s;
    logic [AW:0]       win_sum_s;
    logic [AW-1:0]     win_sel_s;
    logic [6:0]        seg_s;

    assign wr_ok_s    = ({1'b0, wr_addr} < BUF_LEN);
    assign step_pulse = step_pulse_q;

    // Message buffer write; out-of-range addresses are dropped.
    always_comb begin
        msg_d = msg_q;
        if (wr_en && wr_ok_s) begin
            msg_d[wr_addr] = wr_data;
        end else begin
            msg_d = msg_q;
        end
    end

    // Step timer: wraps at step_div-1 (also when step_div shrinks below the count).
    always_comb begin
        step_cnt_d = step_cnt_q;
        step_s     = 1'b0;
        if (step_div == '0) begin
            step_cnt_d = '0;
        end else if (run) begin
            if (step_cnt_q >= step_div - STEP_W'(1)) begin
                step_cnt_d = '0;
                step_s     = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + STEP_W'(1);
            end
        end else begin
            step_cnt_d = step_cnt_q;
        end
        step_pulse_d = step_s;
    end

    // Scroll offset moves one position per step with explicit wrap at both ends.
    always_comb begin
        offset_d = offset_q;
        if (step_s) begin
            if (dir) begin
                offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + AW'(1);
            end else begin
                offset_d = (offset_q == '0) ? OFF_LAST : offset_q - AW'(1);
            end
        end else begin
            offset_d = offset_q;
        end
    end

    // Window mux: digit i shows buffer[(offset + i) mod BUF_DIGITS].
    always_comb begin
        win_sum_s = {1'b0, offset_q} + (AW + 1)'(scan_idx_s);
        if (win_sum_s >= BUF_LEN) begin
            win_sel_s = AW'(win_sum_s - BUF_LEN);
        end else begin
            win_sel_s = win_sum_s[AW-1:0];
        end
        seg_s = seg_decode(msg_q[win_sel_s]);
    end

    // Buffer, offset, step timer and step pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DIGITS; i++) begin
                msg_q[i] <= 4'h0;
            end
            offset_q     <= '0;
            step_cnt_q   <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            msg_q        <= msg_d;
            offset_q     <= offset_d;
            step_cnt_q   <= step_cnt_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    seg_scanner #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scanner (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_i     (seg_s),
        .idx_o     (scan_idx_s),
        .anode_o   (anode),
        .cathode_o (cathode)
    );

endmodule

// File: tb/tb_scroll_display.sv
// Self-checking bench for scroll_display (NUM_DIGITS=4, BUF_DIGITS=6, SCAN_DIV=4).
// Honours SCROLL_GHOST_BLANK_EN when the bundle is built with it.
module tb_scroll_display;
    localparam int ND = 4;
    localparam int BD = 6;
    localparam int SD = 4;
    localparam int SW = 27;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_addr = 3'd0;
    logic [3:0]    wr_data = 4'h0;
    logic          run = 1'b0;
    logic          dir = 1'b0;
    logic [SW-1:0] step_div = '0;
    logic [ND-1:0] anode;
    logic [6:0]    cathode;
    logic          step_pulse;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;

    // reference model state
    int         m_t;
    int         m_off;
    int         m_sc;
    logic [3:0] m_mem [BD];

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } dec_t;

    typedef struct {
        logic run;
        logic dir;
        int   sdiv;
        int   ncyc;
        int   exp_pulses;
    } phase_t;

    dec_t   dv [16];
    phase_t ph [9];

    always #5 clk = ~clk;

    scroll_display #(
        .NUM_DIGITS (ND),
        .BUF_DIGITS (BD),
        .SCAN_DIV   (SD),
        .STEP_W     (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .run        (run),
        .dir        (dir),
        .step_div   (step_div),
        .anode      (anode),
        .cathode    (cathode),
        .step_pulse (step_pulse)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t   = 0;
        m_off = 0;
        m_sc  = 0;
        for (int i = 0; i < BD; i++) m_mem[i] = 4'h0;
    endtask

    // One clock: predict outputs from the model, advance it, then compare at negedge.
    task automatic cycle();
        logic [ND-1:0] ea;
        logic [6:0]    ec;
        logic          ep;
        int            idx;
        idx = (m_t / SD) % ND;
        ea  = ~(4'b0001 << idx);
        ec  = dv[m_mem[(m_off + idx) % BD]].seg;
`ifdef SCROLL_GHOST_BLANK_EN
        if ((m_t % SD) == SD - 1) begin
            ea = 4'hF;
            ec = 7'h7F;
        end
`endif
        ep = 1'b0;
        if (step_div == '0) begin
            m_sc = 0;
        end else if (run) begin
            if (m_sc >= int'(step_div) - 1) begin
                m_sc = 0;
                ep   = 1'b1;
            end else begin
                m_sc++;
            end
        end
        if (ep) m_off = dir ? (m_off + 1) % BD : (m_off + BD - 1) % BD;
        if (wr_en && wr_addr < BD) m_mem[wr_addr] = wr_data;
        m_t++;
        @(posedge clk);
        @(negedge clk);
        chk("anode", 32'(anode), 32'(ea));
        chk("cathode", 32'(cathode), 32'(ec));
        chk("step_pulse", 32'(step_pulse), 32'(ep));
        if (step_pulse) pulses++;
    endtask

    initial begin
        bit found;

        dv[0]  = '{4'h0, 7'h40}; dv[1]  = '{4'h1, 7'h79}; dv[2]  = '{4'h2, 7'h24}; dv[3]  = '{4'h3, 7'h30};
        dv[4]  = '{4'h4, 7'h19}; dv[5]  = '{4'h5, 7'h12}; dv[6]  = '{4'h6, 7'h02}; dv[7]  = '{4'h7, 7'h78};
        dv[8]  = '{4'h8, 7'h00}; dv[9]  = '{4'h9, 7'h10}; dv[10] = '{4'hA, 7'h08}; dv[11] = '{4'hB, 7'h03};
        dv[12] = '{4'hC, 7'h46}; dv[13] = '{4'hD, 7'h21}; dv[14] = '{4'hE, 7'h06}; dv[15] = '{4'hF, 7'h0E};

        ph[0] = '{1'b1, 1'b1, 10, 60, 6};
        ph[1] = '{1'b1, 1'b0, 10, 10, 1};
        ph[2] = '{1'b0, 1'b0, 10, 15, 0};
        ph[3] = '{1'b1, 1'b0, 0, 12, 0};
        ph[4] = '{1'b0, 1'b1, 0, 5, 0};
        ph[5] = '{1'b1, 1'b1, 1, 6, 6};
        ph[6] = '{1'b1, 1'b0, 3, 9, 3};
        ph[7] = '{1'b1, 1'b1, 7, 20, 2};
        ph[8] = '{1'b1, 1'b1, 4, 1, 1};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_anode", 32'(anode), 32'h0000_000F);
        chk("reset_cathode", 32'(cathode), 32'h0000_007F);
        chk("reset_pulse", 32'(step_pulse), 32'h0);
        rst_n = 1'b1;
        model_reset();

        cycle();
        chk("first_anode", 32'(anode), 32'h0000_000E);
        chk("first_cathode", 32'(cathode), 32'h0000_0040);

        // load 1..6 while paused
        pulses = 0;
        for (int i = 0; i < BD; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = 4'(i + 1);
            cycle();
        end
        wr_en = 1'b0;
        repeat (2 * ND * SD) cycle();
        chk("load_no_pulse", 32'(pulses), 32'h0);

        // decode table through digit 0
        for (int k = 0; k < 16; k++) begin
            wr_en   = 1'b1;
            wr_addr = 3'd0;
            wr_data = dv[k].nib;
            cycle();
            wr_en = 1'b0;
            found = 1'b0;
            for (int c = 0; c < ND * SD + 2 && !found; c++) begin
                cycle();
                if (anode == 4'b1110) begin
                    found = 1'b1;
                    chk("decode", 32'(cathode), 32'(dv[k].seg));
                end
            end
            chk("decode_seen", 32'(found), 32'h1);
        end
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 4'h1;
        cycle();

        // out-of-range writes are ignored
        wr_addr = 3'd7;
        wr_data = 4'hF;
        cycle();
        wr_addr = 3'd6;
        cycle();
        wr_en = 1'b0;
        repeat (ND * SD) cycle();

        // scroll phases
        for (int p = 0; p < 9; p++) begin
            run      = ph[p].run;
            dir      = ph[p].dir;
            step_div = SW'(ph[p].sdiv);
            pulses   = 0;
            repeat (ph[p].ncyc) cycle();
            chk("phase_pulses", 32'(pulses), 32'(ph[p].exp_pulses));
        end

        // write buf[offset] on the same edge as a step
        run      = 1'b1;
        step_div = '0;
        cycle();
        step_div = SW'(3);
        dir      = 1'b1;
        cycle();
        cycle();
        wr_en    = 1'b1;
        wr_addr  = 3'(m_off);
        wr_data  = 4'hA;
        cycle();
        chk("wr_step_pulse", 32'(step_pulse), 32'h1);
        wr_en = 1'b0;
        run   = 1'b0;
        repeat (2 * ND * SD) cycle();

        // randomized traffic
        for (int r = 0; r < 400; r++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                run      = 1'($urandom);
                dir      = 1'($urandom);
                step_div = SW'($urandom_range(0, 5));
            end
            cycle();
        end

        // asynchronous reset mid-scan
        run      = 1'b1;
        step_div = SW'(1);
        wr_en    = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_anode", 32'(anode), 32'h0000_000F);
        chk("async_rst_cathode", 32'(cathode), 32'h0000_007F);
        chk("async_rst_pulse", 32'(step_pulse), 32'h0);
        run      = 1'b0;
        step_div = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2 * ND * SD) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scroll_display.md
# scroll_display

Parametrised scrolling multiplexed seven-segment display controller. It holds a writable message buffer of hex nibbles and shows a NUM_DIGITS-wide window of it on a common-anode display. The window scrolls left or right at a runtime-programmable rate and can be paused. It sits between board-level drivers (anode/cathode pins) and any control logic that loads messages.

## Interface
- NUM_DIGITS, 8: physical digits driven; ≥ 2.
- BUF_DIGITS, 16: message buffer length in nibbles; ≥ NUM_DIGITS.
- SCAN_DIV, 100000: clk cycles each digit is lit per refresh pass; ≥ 2.
- STEP_W, 27: width of step_div.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe for the message buffer.
- wr_addr  in  clog2(BUF_DIGITS)  nibble index to write.
- wr_data  in  4  nibble value 0x0–0xF.
- run  in  1  1 = scrolling enabled, 0 = hold position.
- dir  in  1  0 = scroll left, 1 = scroll right.
- step_div  in  STEP_W  clk cycles per scroll step; 0 = frozen.
- anode  out  NUM_DIGITS  digit enables, active-low, one-hot-low when lit.
- cathode  out  7  segments {g,f,e,d,c,b,a}, active-low.
- step_pulse  out  1  one-cycle high on each scroll step.

## Operation
- Reset values:
  - anode all 1, cathode 7'h7F, step_pulse 0.
  - offset 0, scan index 0, scan counter 0, step counter 0.
  - All buffer nibbles 0.
- Buffer write: when wr_en=1, buf[wr_addr] <= wr_data on the next edge. If wr_addr ≥ BUF_DIGITS, the write is ignored.
- Window mapping: digit i (anode[i], i=0 rightmost) shows buf[(offset+i) mod BUF_DIGITS].
- Step counter:
  - Counts only while run=1 and step_div≠0.
  - When it equals step_div−1, it wraps to 0 and a step occurs.
  - run=0 holds the counter value.
  - step_div=0 clears the counter and suppresses steps.
- Step, dir=0 (left): offset <= (offset−1) mod BUF_DIGITS, so content moves toward higher anode index.
- Step, dir=1 (right): offset <= (offset+1) mod BUF_DIGITS.
- Offset wraps explicitly at 0 and BUF_DIGITS−1; BUF_DIGITS need not be a power of two.
- Scanner:
  - Scan counter counts 0..SCAN_DIV−1.
  - On wrap, scan index advances 0..NUM_DIGITS−1, then wraps to 0.
  - anode[idx]=0, all other anode bits 1.
  - cathode = hex decode of the selected nibble. Decode: 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.

## Timing
- anode and cathode are registered.
- Outputs are recomputed every cycle from the current scan index, offset and buffer, and appear one edge later.
- A buffer write or offset change therefore reaches the lit digit within 1 cycle.
- step_pulse is asserted in the cycle after the edge that updates offset, and lasts exactly 1 cycle.
- Step period is exactly step_div cycles while run=1.
- Changing step_div mid-count: the new value is compared immediately. If the counter is already ≥ the new step_div−1, it wraps on the next edge and steps.
- dir is sampled at the step edge only.
- Write and step in the same cycle: both take effect; neither is lost.
- Reset mid-operation: all state clears asynchronously; outputs blank immediately.

## Configuration
- SCROLL_GHOST_BLANK_EN:
  - Defined: on every scan-index advance, anode is forced all-1 (cathode 7'h7F) for one cycle before the new digit is lit. Each digit is lit SCAN_DIV−1 cycles.
  - Undefined: digits switch directly, with no blank cycle.

## Structure
- Package scroll_display_pkg holds:
  - the 16-entry seven-segment constant table and a decode function,
  - the SEG_OFF = 7'h7F constant,
  - the segment bit-order definition.
- Sub-module seg_scanner holds the scan counter, scan index, anode generation and ghost blanking; it is parameterised by NUM_DIGITS and SCAN_DIV.
- The top level holds the buffer, offset/step logic and the window mux.

## Test plan
Bench parameters: NUM_DIGITS=4, BUF_DIGITS=6, SCAN_DIV=4.
- Reset: rst_n low → anode 4'hF, cathode 7'h7F, step_pulse 0. After release, the first lit digit anode=4'b1110 shows 7'h40.
- Load buf = 1,2,3,4,5,6 with run=0 → digits 0..3 show 7'h79, 7'h24, 7'h30, 7'h19, one scan pass each. No step_pulse.
- run=1, dir=1, step_div=10 → step_pulse every 10 cycles; offset goes 1,2,…,5,0. At offset=4, digit 3 shows buf[1]=2 (7'h24).
- dir=0 from offset 0 → the next step gives offset=5, digit 0 shows 6 (7'h02).
- step_div=0 and run toggling → no step_pulse, offset unchanged. A wr_addr=7 write leaves the buffer unchanged.
- Write buf[offset] at the same edge as a step → the new value and the new offset both appear. Assert rst_n mid-scan → immediate blank.
